// File: rtl/light_circuit_tester.sv
`default_nettype none
// ============================================================================
// Module      : light_circuit_tester
// Description : Exhaustive functional tester for a 3-switch light circuit
//               whose intended behaviour is F = C & (A | B). Each of the
//               eight switch vectors is driven onto a_out/b_out/c_out and
//               held for SETTLE_CYCLES+1 cycles. The returned light f_in is
//               synchronised, then compared against the expected value in
//               the last cycle of that hold window. Failures are collected
//               into a per-vector bitmap and a count.
// Ports       :
//   clk         system clock, rising-edge active
//   rst         asynchronous active-high reset
//   start       begin a run (ignored while busy)
//   f_in        light F from circuit under test (asynchronous to clk)
//   a_out       switch A drive (vector MSB)
//   b_out       switch B drive
//   c_out       switch C drive (vector LSB)
//   busy        run in progress
//   done        run finished, results valid
//   pass        no vector failed (valid with done)
//   fail_count  number of failing vectors, 0..8
//   fail_vec    bit i set when vector i failed
// Revision    : 1.0 - initial release
// ============================================================================
module light_circuit_tester #(
  parameter int SETTLE_CYCLES = 4  // legal range 3..15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       f_in,
  output logic       a_out,
  output logic       b_out,
  output logic       c_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] fail_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] C_CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_idx, w_idx_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic [3:0] r_fail_count, w_fail_count_nxt;
  logic [7:0] r_fail_vec, w_fail_vec_nxt;
  logic       r_busy, w_busy_nxt;
  logic       r_done, w_done_nxt;
  logic       r_pass, w_pass_nxt;

  // Two-flop synchroniser for the asynchronous light input
  logic r_sync1, r_sync2;

  logic w_exp;
  logic w_mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= f_in;
      r_sync2 <= r_sync1;
    end
  end

  // Expected light for the vector currently driven: C & (A | B)
  assign w_exp      = r_idx[0] & (r_idx[2] | r_idx[1]);
  assign w_mismatch = (r_sync2 != w_exp);

  // State and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_idx        <= 3'd0;
      r_cnt        <= 4'd0;
      r_fail_count <= 4'd0;
      r_fail_vec   <= 8'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_pass       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_fail_count <= w_fail_count_nxt;
      r_fail_vec   <= w_fail_vec_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_pass       <= w_pass_nxt;
    end
  end

  // Next-state and datapath logic
  always_comb begin
    w_state_nxt      = r_state;
    w_idx_nxt        = r_idx;
    w_cnt_nxt        = r_cnt;
    w_fail_count_nxt = r_fail_count;
    w_fail_vec_nxt   = r_fail_vec;
    w_busy_nxt       = r_busy;
    w_done_nxt       = r_done;
    w_pass_nxt       = r_pass;

    case (r_state)
      ST_IDLE, ST_DONE: begin
        // Results of a finished run persist until the next start
        if (start) begin
          w_state_nxt      = ST_SETTLE;
          w_idx_nxt        = 3'd0;
          w_cnt_nxt        = 4'd0;
          w_fail_count_nxt = 4'd0;
          w_fail_vec_nxt   = 8'd0;
          w_busy_nxt       = 1'b1;
          w_done_nxt       = 1'b0;
          w_pass_nxt       = 1'b0;
        end
      end

      ST_SETTLE: begin
        // Counter value is don't-care on exit; SAMPLE clears it
        w_cnt_nxt = r_cnt + 4'd1;
        if (r_cnt == C_CNT_LAST) begin
          w_state_nxt = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (w_mismatch) begin
          w_fail_vec_nxt[r_idx] = 1'b1;
          if (r_fail_count != 4'd8) begin
            w_fail_count_nxt = r_fail_count + 4'd1;
          end
        end
        if (r_idx != 3'd7) begin
          w_idx_nxt   = r_idx + 3'd1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_SETTLE;
        end else begin
          // Last vector: pass must reflect this cycle's comparison too
          w_state_nxt = ST_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_pass_nxt  = (w_fail_count_nxt == 4'd0);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Switch drives come straight from the vector index; DONE leaves idx at 7
  assign a_out      = r_idx[2];
  assign b_out      = r_idx[1];
  assign c_out      = r_idx[0];
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign fail_count = r_fail_count;
  assign fail_vec   = r_fail_vec;

endmodule
`default_nettype wire

// File: tb/tb_light_circuit_tester.sv
`default_nettype none
// ============================================================================
// Module      : tb_light_circuit_tester
// Description : Scoreboard bench for light_circuit_tester. The circuit under
//               test is emulated by an 8-entry truth table indexed by the
//               switch outputs; each completed run's expected result is
//               derived from that table and queued, and a monitor checks
//               the DUT result when done rises.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_light_circuit_tester;

  localparam int S    = 4;
  localparam int HOLD = S + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       f_in;
  logic       a_out, b_out, c_out;
  logic       busy, done, pass;
  logic [3:0] fail_count;
  logic [7:0] fail_vec;

  logic [7:0] tbl;

  typedef struct {
    logic [3:0] fc;
    logic [7:0] fv;
    logic       pass;
  } exp_t;

  exp_t sbq[$];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  // Emulated circuit under test: truth table lookup on the switch drives
  assign f_in = tbl[{a_out, b_out, c_out}];

  light_circuit_tester #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .f_in       (f_in),
    .a_out      (a_out),
    .b_out      (b_out),
    .c_out      (c_out),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .fail_count (fail_count),
    .fail_vec   (fail_vec)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, req);
  endtask

  // Reference: compare each table entry with the intended light equation
  function automatic exp_t model(input logic [7:0] t);
    exp_t e;
    int   a, b, c;
    bit   want;
    e.fv = 8'd0;
    e.fc = 4'd0;
    for (int i = 0; i < 8; i++) begin
      a    = i / 4;
      b    = (i / 2) % 2;
      c    = i % 2;
      want = (c == 1) && ((a == 1) || (b == 1));
      if (t[i] != want) begin
        e.fv[i] = 1'b1;
        e.fc    = e.fc + 4'd1;
      end
    end
    e.pass = (e.fc == 4'd0);
    return e;
  endfunction

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run(input logic [7:0] t);
    exp_t e;
    @(negedge clk);
    tbl = t;
    e = model(t);
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);
    chk("hold_done", 32'(done), 32'd1);
    chk("hold_fvec", 32'(fail_vec), 32'(e.fv));
    chk("hold_fcnt", 32'(fail_count), 32'(e.fc));
  endtask

  // Monitor: cycle position, vector sequence and scoreboard pop on done
  initial begin : monitor
    int   cnt;
    logic pb, pd;
    exp_t e;
    cnt = 0;
    pb  = 1'b0;
    pd  = 1'b0;
    forever begin
      @(negedge clk);
      if (busy && !pb) begin
        cnt = 0;
        chk("accept_clear", {20'd0, done, pass, fail_count, fail_vec}, 32'd0);
      end else begin
        cnt++;
      end
      if (busy) chk("vec_out", 32'({a_out, b_out, c_out}), 32'(cnt / HOLD));
      if (done && !busy) chk("done_out", 32'({a_out, b_out, c_out}), 32'd7);
      if (done && !pd) begin
        chk("done_edge", 32'(cnt), 32'(8 * HOLD));
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'(sbq.size()), 32'd1);
        end else begin
          e = sbq.pop_front();
          chk("sb_fcnt", 32'(fail_count), 32'(e.fc));
          chk("sb_fvec", 32'(fail_vec), 32'(e.fv));
          chk("sb_pass", 32'(pass), 32'(e.pass));
        end
      end
      pb = busy;
      pd = done;
    end
  end

  initial begin : stim
    exp_t e;
    int   n;
    rst   = 1'b1;
    start = 1'b0;
    tbl   = 8'hA8;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 32'({a_out, b_out, c_out}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_fcnt", 32'(fail_count), 32'd0);
    chk("rst_fvec", 32'(fail_vec), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Correct circuit, stuck-at-0, stuck-at-1
    run(8'hA8);
    run(8'h00);
    run(8'hFF);

    // Reset in the middle of vector 4's settle window
    @(negedge clk);
    tbl   = 8'hA8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while ({a_out, b_out, c_out} !== 3'b100 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_idx4", 32'({a_out, b_out, c_out}), 32'd4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_out", 32'({a_out, b_out, c_out}), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_fvec", 32'(fail_vec), 32'd0);
    chk("abort_fcnt", 32'(fail_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_idle", 32'(busy), 32'd0);
    run(8'hA8);

    // start held through a run, restarting from DONE, then random pulses
    @(negedge clk);
    tbl = 8'($urandom);
    e = model(tbl);
    sbq.push_back(e);
    sbq.push_back(e);
    start = 1'b1;
    @(negedge clk);
    wait_done();
    @(negedge clk);
    chk("restart_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 20; i++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    wait_done();
    repeat (3) @(negedge clk);

    // rst dominates a simultaneous start
    rst   = 1'b1;
    start = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_start_busy", 32'(busy), 32'd0);
    chk("rst_start_done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_start_idle", 32'(busy), 32'd0);

    // Random faulty circuits
    for (int i = 0; i < 6; i++) begin
      run(8'($urandom));
    end

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
